// File: rtl/elevator_group_ctrl_if.sv
// Request/status bundle between the board button layer and the elevator controller.
// master: request source (buttons, bench); slave: the controller.
interface elevator_group_ctrl_if #(
    parameter int FLOORS = 5
) ();
    localparam int FW = $clog2(FLOORS);

    logic [FLOORS-1:0] hall_up;
    logic [FLOORS-1:0] hall_dn;
    logic [FLOORS-1:0] cab;
    logic              door_hold;
    logic [FW-1:0]     floor_o;
    logic [1:0]        dir_o;
    logic              moving;
    logic              door_open;
    logic [FLOORS-1:0] led_up;
    logic [FLOORS-1:0] led_dn;
    logic [FLOORS-1:0] led_cab;

    modport master (
        output hall_up, hall_dn, cab, door_hold,
        input  floor_o, dir_o, moving, door_open, led_up, led_dn, led_cab
    );

    modport slave (
        input  hall_up, hall_dn, cab, door_hold,
        output floor_o, dir_o, moving, door_open, led_up, led_dn, led_cab
    );
endinterface

// File: rtl/elevator_group_ctrl.sv
// Single-car SCAN elevator controller: latches hall/cab requests, steps the car one
// floor per TRAVEL cycles, holds the door open for DWELL cycles at serviced floors.
// Optional feature macro ELEV_PARK_EN: return to PARK_FLOOR after PARK_IDLE idle cycles.
//
// state | meaning
// IDLE  | car stopped, door closed, no direction
// MOVE  | travelling in dir_o, travel timer running
// DOOR  | door open at floor_o, dwell timer running
// PARK  | (ELEV_PARK_EN) unrequested travel toward PARK_FLOOR
module elevator_group_ctrl #(
    parameter int FLOORS     = 5,
    parameter int TRAVEL     = 50,
    parameter int DWELL      = 250,
    parameter int PARK_FLOOR = 0,
    parameter int PARK_IDLE  = 1500
) (
    input logic                 clk_50hz,
    input logic                 rst,
    elevator_group_ctrl_if.slave bus
);
    localparam int FW = $clog2(FLOORS);
    localparam int TW = $clog2(TRAVEL + 1);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [FLOORS-1:0] UP_OK = ~(FLOORS'(1) << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_OK = ~FLOORS'(1);
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

`ifdef ELEV_PARK_EN
    localparam int IW = $clog2(PARK_IDLE + 1);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_PARK} state_t;
    logic [IW-1:0] idle_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;
`endif

    state_t            state;
    logic [FW-1:0]     floor_q;
    logic [1:0]        dir_q;
    logic              moving_q, door_q;
    logic [FLOORS-1:0] up_q, dn_q, cab_q;
    logic [TW-1:0]     travel_cnt;
    logic [DW-1:0]     dwell_cnt;

    logic              going_up, at_end, arrive, open_here, here_req;
    logic              any_above, any_below, ahead_nf, hall_dir_nf, hall_opp_nf, stop_nf;
    logic [FW-1:0]     nf;
    logic [FLOORS-1:0] all_req, here, nf_bit;
    logic [FLOORS-1:0] req_up, req_dn, req_cab;
    logic [FLOORS-1:0] set_up, set_dn, set_cab, clr_up, clr_dn, clr_cab;

    function automatic logic [FLOORS-1:0] bit_of(input logic [FW-1:0] f);
        bit_of = FLOORS'(1) << f;
    endfunction

    function automatic logic [FLOORS-1:0] above_of(input logic [FW-1:0] f);
        for (int i = 0; i < FLOORS; i++) above_of[i] = (FW'(i) > f);
    endfunction

    function automatic logic [FLOORS-1:0] below_of(input logic [FW-1:0] f);
        for (int i = 0; i < FLOORS; i++) below_of[i] = (FW'(i) < f);
    endfunction

    // Scheduling decisions from registered state plus latch set/clear masks.
    always_comb begin
        going_up    = (dir_q == DIR_UP);
        all_req     = up_q | dn_q | cab_q;
        here        = bit_of(floor_q);
        any_above   = |(all_req & above_of(floor_q));
        any_below   = |(all_req & below_of(floor_q));
        at_end      = going_up ? (floor_q == FW'(FLOORS - 1)) : (floor_q == '0);
        nf          = going_up ? floor_q + FW'(1) : floor_q - FW'(1);
        nf_bit      = bit_of(nf);
        ahead_nf    = going_up ? |(all_req & above_of(nf)) : |(all_req & below_of(nf));
        hall_dir_nf = going_up ? |(up_q & nf_bit) : |(dn_q & nf_bit);
        hall_opp_nf = going_up ? |(dn_q & nf_bit) : |(up_q & nf_bit);
        stop_nf     = ~at_end & (|(cab_q & nf_bit) | hall_dir_nf | (hall_opp_nf & ~ahead_nf));
`ifdef ELEV_PARK_EN
        arrive      = (state == S_MOVE || state == S_PARK) && travel_cnt == '0;
`else
        arrive      = (state == S_MOVE) && travel_cnt == '0;
`endif
        open_here   = (state == S_IDLE) && |(all_req & here);
        req_up      = bus.hall_up & UP_OK;
        req_dn      = bus.hall_dn & DN_OK;
        req_cab     = bus.cab;
        here_req    = |((req_up | req_dn | req_cab) & here);
        // a call for the floor whose door is open is answered by the open door itself
        set_up      = req_up  & ~((state == S_DOOR) ? here : '0);
        set_dn      = req_dn  & ~((state == S_DOOR) ? here : '0);
        set_cab     = req_cab & ~((state == S_DOOR) ? here : '0);
        clr_up      = '0;
        clr_dn      = '0;
        clr_cab     = '0;
        if (open_here) begin
            clr_up  = here;
            clr_dn  = here;
            clr_cab = here;
        end else if (arrive && stop_nf) begin
            clr_cab = nf_bit;
            if (going_up) begin
                clr_up = nf_bit;
                clr_dn = ahead_nf ? '0 : nf_bit;
            end else begin
                clr_dn = nf_bit;
                clr_up = ahead_nf ? '0 : nf_bit;
            end
        end
    end

    // Car FSM, request latches and timers; every output comes straight from a flop.
    always_ff @(posedge clk_50hz or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= DIR_IDLE;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            up_q       <= '0;
            dn_q       <= '0;
            cab_q      <= '0;
            travel_cnt <= '0;
            dwell_cnt  <= '0;
`ifdef ELEV_PARK_EN
            idle_cnt   <= '0;
`endif
        end else begin
            up_q  <= (up_q | set_up) & ~clr_up;
            dn_q  <= (dn_q | set_dn) & ~clr_dn;
            cab_q <= (cab_q | set_cab) & ~clr_cab;
`ifdef ELEV_PARK_EN
            idle_cnt <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (open_here) begin
                        state     <= S_DOOR;
                        door_q    <= 1'b1;
                        dwell_cnt <= DW'(DWELL - 1);
                    end else if (any_above || any_below) begin
                        state      <= S_MOVE;
                        dir_q      <= any_above ? DIR_UP : DIR_DN;
                        moving_q   <= 1'b1;
                        travel_cnt <= TW'(TRAVEL - 1);
                    end
`ifdef ELEV_PARK_EN
                    else if (floor_q != FW'(PARK_FLOOR)) begin
                        if (idle_cnt == IW'(PARK_IDLE - 1)) begin
                            state      <= S_PARK;
                            dir_q      <= (floor_q > FW'(PARK_FLOOR)) ? DIR_DN : DIR_UP;
                            moving_q   <= 1'b1;
                            travel_cnt <= TW'(TRAVEL - 1);
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
`endif
                end
                S_MOVE: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - TW'(1);
                    end else if (at_end || !(stop_nf || ahead_nf)) begin
                        // nothing left to reach in this direction; stop without opening
                        state    <= S_IDLE;
                        dir_q    <= DIR_IDLE;
                        moving_q <= 1'b0;
                        if (!at_end) floor_q <= nf;
                    end else begin
                        floor_q    <= nf;
                        travel_cnt <= TW'(TRAVEL - 1);
                        if (stop_nf) begin
                            state     <= S_DOOR;
                            moving_q  <= 1'b0;
                            door_q    <= 1'b1;
                            dwell_cnt <= DW'(DWELL - 1);
                        end
                    end
                end
                S_DOOR: begin
                    if (bus.door_hold || here_req) begin
                        dwell_cnt <= DW'(DWELL - 1);
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else begin
                        door_q <= 1'b0;
                        if ((dir_q == DIR_DN && any_below) || any_above || any_below) begin
                            state      <= S_MOVE;
                            moving_q   <= 1'b1;
                            travel_cnt <= TW'(TRAVEL - 1);
                            dir_q      <= ((dir_q == DIR_DN && any_below) || !any_above) ? DIR_DN : DIR_UP;
                        end else begin
                            state <= S_IDLE;
                            dir_q <= DIR_IDLE;
                        end
                    end
                end
`ifdef ELEV_PARK_EN
                S_PARK: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - TW'(1);
                    end else begin
                        floor_q    <= nf;
                        travel_cnt <= TW'(TRAVEL - 1);
                        if (stop_nf) begin
                            state     <= S_DOOR;
                            moving_q  <= 1'b0;
                            door_q    <= 1'b1;
                            dwell_cnt <= DW'(DWELL - 1);
                        end else if (all_req != '0 || nf == FW'(PARK_FLOOR)) begin
                            // home reached, or a request abandons the park: hand back to IDLE
                            state    <= S_IDLE;
                            dir_q    <= DIR_IDLE;
                            moving_q <= 1'b0;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.floor_o   = floor_q;
    assign bus.dir_o     = dir_q;
    assign bus.moving    = moving_q;
    assign bus.door_open = door_q;
    assign bus.led_up    = up_q;
    assign bus.led_dn    = dn_q;
    assign bus.led_cab   = cab_q;
endmodule
